// File: rtl/shift_chain_pkg.sv
// Shared types and helpers for the serial shift-chain controller.
package shift_chain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } state_t;

    localparam int MAX_REQ = 32;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Nearest requester after 'last' wins; returns -1 when nothing is requesting.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int last, input int n);
        int idx;
        rr_pick = -1;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (req[idx[4:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/shift_chain_ctrl_arb.sv
// Combinational round-robin arbiter; the pointer register lives in the parent.
module rr_arbiter
    import shift_chain_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    logic [MAX_REQ-1:0] req_ext;
    int                 pick;

    always_comb begin
        req_ext  = MAX_REQ'(req);
        pick     = rr_pick(req_ext, int'(last), NREQ);
        grant    = '0;
        grant_id = '0;
        if (en && pick >= 0) begin
            grant    = NREQ'(1) << pick;
            grant_id = ID_W'(pick);
        end
    end

endmodule

// File: rtl/shift_chain_ctrl.sv
// Round-robin scheduler sharing one WORD_W-deep serial shift chain between NREQ
// parallel requesters; each word is shifted in LSB-first and the old contents returned.
module shift_chain_ctrl
    import shift_chain_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WORD_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WORD_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     sr_en,
    output logic                     sr_din,
    input  logic                     sr_dout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [clog2_min1(NREQ)-1:0] rsp_id,
    output logic [WORD_W-1:0]        rsp_data,
    output logic                     busy
);

    localparam int ID_W  = clog2_min1(NREQ);
    localparam int CNT_W = clog2_min1(WORD_W);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [WORD_W-1:0]   word, word_n;
    logic [WORD_W-1:0]   rsp_data_n;
    logic [ID_W-1:0]     last, last_n;
    logic [ID_W-1:0]     rsp_id_n;
    logic [ID_W-1:0]     grant_id;
    logic [WORD_W-1:0]   sel_word;
    logic                sr_en_n, sr_din_n;
    logic                xfer;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req      (req_valid),
        .last     (last),
        .en       (state == IDLE),
        .grant    (req_ready),
        .grant_id (grant_id)
    );

    assign xfer      = |req_ready;
    assign sel_word  = req_data[int'(grant_id)*WORD_W +: WORD_W];
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // sr_en/sr_din are computed one cycle ahead so they leave the block registered.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        word_n     = word;
        rsp_data_n = rsp_data;
        rsp_id_n   = rsp_id;
        last_n     = last;
        sr_en_n    = 1'b0;
        sr_din_n   = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_n    = SHIFT;
                    word_n     = sel_word;
                    rsp_id_n   = grant_id;
                    last_n     = grant_id;
                    cnt_n      = '0;
                    rsp_data_n = '0;
                    sr_en_n    = 1'b1;
                    sr_din_n   = sel_word[0];
                end
            end
            SHIFT: begin
                rsp_data_n[cnt] = sr_dout;
                if (cnt == CNT_W'(WORD_W-1)) begin
                    state_n = RESP;
                end else begin
                    cnt_n    = cnt + 1'b1;
                    sr_en_n  = 1'b1;
                    sr_din_n = word[cnt + 1'b1];
                end
            end
            RESP: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            word     <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            last     <= ID_W'(NREQ-1);
            sr_en    <= 1'b0;
            sr_din   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            word     <= word_n;
            rsp_data <= rsp_data_n;
            rsp_id   <= rsp_id_n;
            last     <= last_n;
            sr_en    <= sr_en_n;
            sr_din   <= sr_din_n;
        end
    end

    a_en_in_shift: assert property (@(posedge clk) disable iff (!rstn) sr_en |-> state == SHIFT);
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rstn)
        (rsp_valid && !rsp_ready) |=> ($stable(rsp_data) && $stable(rsp_id)));

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Self-checking bench for shift_chain_ctrl with a behavioural chain and scheduler model.
module tb_shift_chain_ctrl;

    localparam int NREQ   = 4;
    localparam int WORD_W = 8;
    localparam int ID_W   = 2;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WORD_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   sr_en, sr_din, sr_dout;
    logic                   rsp_valid, rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WORD_W-1:0]      rsp_data;
    logic                   busy;

    logic [WORD_W-1:0]      chain;
    int                     total = 0;
    int                     bad = 0;
    int                     last_m;
    logic [WORD_W-1:0]      prev_m;

    shift_chain_ctrl #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .sr_en     (sr_en),
        .sr_din    (sr_din),
        .sr_dout   (sr_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // The shift chain itself: din enters at the MSB, dout is the LSB.
    always @(posedge clk) begin
        if (!rstn) chain <= '0;
        else if (sr_en) chain <= {sr_din, chain[WORD_W-1:1]};
    end
    assign sr_dout = chain[0];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int modelPick(input logic [NREQ-1:0] mask);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last_m + k) % NREQ;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [NREQ-1:0] mask, input logic [NREQ*WORD_W-1:0] data);
        req_valid = mask;
        req_data  = data;
    endtask

    // Called right after a negedge with the controller idle; returns the same way.
    task automatic runTxn(input logic [NREQ-1:0] mask, input int hold, input int abortAt,
                          input int pulseAt, input logic [NREQ*WORD_W-1:0] data);
        int g;
        logic [WORD_W-1:0] w;
        rsp_ready = 1'b0;
        applyStimulus(mask, data);
        #1;
        g = modelPick(mask);
        w = data[g*WORD_W +: WORD_W];
        checkOutput("idle_busy", busy, 0);
        checkOutput("grant", req_ready, 32'(1) << g);
        for (int k = 0; k < WORD_W; k++) begin
            @(negedge clk);
            checkOutput("shift_en", sr_en, 1);
            checkOutput("shift_din", sr_din, w[k]);
            checkOutput("shift_busy", busy, 1);
            checkOutput("shift_rsp_valid", rsp_valid, 0);
            if (k == abortAt) begin
                rstn = 1'b0;
                applyStimulus('0, data);
                @(negedge clk);
                checkOutput("abort_en", sr_en, 0);
                checkOutput("abort_din", sr_din, 0);
                checkOutput("abort_rsp_valid", rsp_valid, 0);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_rsp_id", rsp_id, 0);
                checkOutput("abort_rsp_data", rsp_data, 0);
                rstn   = 1'b1;
                last_m = NREQ - 1;
                prev_m = '0;
                return;
            end
            if (k == pulseAt) begin
                applyStimulus(4'b0010, data);
                #1;
                checkOutput("ready_in_shift", req_ready, 0);
            end else begin
                applyStimulus('0, data);
            end
        end
        @(negedge clk);
        checkOutput("resp_valid", rsp_valid, 1);
        checkOutput("resp_en", sr_en, 0);
        checkOutput("resp_din", sr_din, 0);
        checkOutput("resp_id", rsp_id, g);
        checkOutput("resp_data", rsp_data, prev_m);
        checkOutput("chain_word", chain, w);
        for (int h = 0; h < hold; h++) begin
            applyStimulus(mask, data);
            @(negedge clk);
            checkOutput("hold_valid", rsp_valid, 1);
            checkOutput("hold_id", rsp_id, g);
            checkOutput("hold_data", rsp_data, prev_m);
            checkOutput("hold_ready", req_ready, 0);
            checkOutput("hold_en", sr_en, 0);
        end
        applyStimulus('0, data);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("after_valid", rsp_valid, 0);
        checkOutput("after_busy", busy, 0);
        rsp_ready = 1'b0;
        last_m = g;
        prev_m = w;
    endtask

    initial begin
        rstn      = 1'b0;
        rsp_ready = 1'b0;
        applyStimulus('0, '0);
        repeat (2) @(negedge clk);
        checkOutput("rst_en", sr_en, 0);
        checkOutput("rst_din", sr_din, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_id", rsp_id, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_busy", busy, 0);
        rstn   = 1'b1;
        last_m = NREQ - 1;
        prev_m = '0;

        $display("[TB] bit order and capture");
        runTxn(4'b0001, 0, -1, -1, 32'h0000_00A5);
        runTxn(4'b0001, 0, -1, -1, 32'h0000_003C);

        $display("[TB] all requesters valid");
        for (int i = 0; i < 5; i++) runTxn(4'b1111, 0, -1, -1, $urandom);

        $display("[TB] pointer rotation");
        runTxn(4'b0100, 0, -1, -1, $urandom);
        runTxn(4'b1010, 0, -1, -1, $urandom);
        runTxn(4'b1010, 0, -1, -1, $urandom);

        $display("[TB] response backpressure");
        runTxn(4'b0001, 5, -1, -1, $urandom);

        $display("[TB] reset during shift");
        runTxn(4'b0010, 0, 3, -1, $urandom);
        runTxn(4'b1001, 0, -1, -1, $urandom);

        $display("[TB] request pulse during shift");
        runTxn(4'b0001, 0, -1, 2, $urandom);
        runTxn(4'b0001, 0, -1, -1, $urandom);

        $display("[TB] random transactions");
        for (int i = 0; i < 12; i++)
            runTxn(4'($urandom_range(1, 15)), $urandom_range(0, 3), -1, -1, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
